// File: rtl/gf_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gf_stream_pkg
// Description : Shared state encoding and counter sizing for gf_matrix_stream.
// Revision    : 1.0 - initial release
// ============================================================================
package gf_stream_pkg;

   typedef enum logic [1:0] {
      LOAD    = 2'd0,
      COMPUTE = 2'd1,
      SEND    = 2'd2
   } state_t;

   // Width of a counter that walks every element of one job (A then b).
   function automatic int cnt_width(input int rows, input int cols);
      int n;
      n = rows * cols + cols;
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_multiplication.sv
`default_nettype none
// ============================================================================
// Module      : matrix_multiplication
// Description : Combinational C = A x B over GF(2^N) reduced by polynomial p.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_multiplication #(
   parameter int N     = 8,
   parameter int ROW_A = 4,
   parameter int COL_A = 4,
   parameter int COL_B = 1
) (
   input  logic [N:0]                 i_p,
   input  logic [ROW_A*COL_A*N-1:0]   i_a,
   input  logic [COL_A*COL_B*N-1:0]   i_b,
   output logic [ROW_A*COL_B*N-1:0]   o_c
);

   // Shift-and-add multiply, folding the overflow bit back in with the polynomial.
   function automatic logic [N-1:0] gf_mul(input logic [N-1:0] x,
                                           input logic [N-1:0] y,
                                           input logic [N:0]   poly);
      logic [N:0] acc;
      acc = '0;
      for (int i = N - 1; i >= 0; i--) begin
         acc = {acc[N-1:0], 1'b0};
         if (acc[N]) acc = acc ^ poly;
         if (y[i])   acc = acc ^ {1'b0, x};
      end
      return acc[N-1:0];
   endfunction

   for (genvar r = 0; r < ROW_A; r++) begin : g_row
      for (genvar k = 0; k < COL_B; k++) begin : g_col
         logic [N-1:0] w_sum;
         always_comb begin
            w_sum = '0;
            for (int j = 0; j < COL_A; j++) begin
               w_sum = w_sum ^ gf_mul(i_a[(r*COL_A+j)*N +: N],
                                      i_b[(j*COL_B+k)*N +: N], i_p);
            end
         end
         assign o_c[(r*COL_B+k)*N +: N] = w_sum;
      end
   end

endmodule
`default_nettype wire

// File: rtl/gf_matrix_stream.sv
`default_nettype none
// ============================================================================
// Module      : gf_matrix_stream
// Description : Streams in A (row-major) and b, returns s = A x b over GF(2^N).
// Revision    : 1.0 - initial release
// ============================================================================
module gf_matrix_stream
   import gf_stream_pkg::*;
#(
   parameter int N    = 8,
   parameter int ROWS = 4,
   parameter int COLS = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N:0]   p,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_data,
   output logic         out_last
);

   localparam int c_a_len = ROWS * COLS;
   localparam int c_cnt_w = cnt_width(ROWS, COLS);
   localparam int c_idx_w = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(ROWS * COLS + COLS - 1);
   localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(ROWS - 1);

   state_t                  r_state;
   logic [c_cnt_w-1:0]      r_ld_cnt;
   logic [c_idx_w-1:0]      r_out_idx;
   logic [ROWS*COLS*N-1:0]  r_a;
   logic [COLS*N-1:0]       r_b;
   logic [N:0]              r_p;
   logic [ROWS*N-1:0]       r_res;
   logic                    r_in_ready;
   logic                    r_out_valid;
   logic                    r_out_last;
   logic [N-1:0]            r_out_data;

   logic [ROWS*N-1:0]       w_res;
   logic [c_idx_w-1:0]      w_sel_idx;
   logic [N-1:0]            w_sel_data;
   logic                    w_accept;
   logic                    w_last_in;

   assign w_accept  = in_valid && r_in_ready;
   assign w_last_in = w_accept && (r_ld_cnt == c_cnt_last);

   // While an element is on the bus the next one to present is idx+1.
   assign w_sel_idx = r_out_valid ? (r_out_idx + c_idx_w'(1)) : r_out_idx;

   always_comb begin
      w_sel_data = '0;
      for (int i = 0; i < ROWS; i++) begin
         if (w_sel_idx == c_idx_w'(i)) w_sel_data = r_res[i*N +: N];
      end
   end

   matrix_multiplication #(
      .N     (N),
      .ROW_A (ROWS),
      .COL_A (COLS),
      .COL_B (1)
   ) u_matrix_multiplication (
      .i_p (r_p),
      .i_a (r_a),
      .i_b (r_b),
      .o_c (w_res)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= LOAD;
         r_ld_cnt    <= '0;
         r_out_idx   <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_p         <= '0;
         r_res       <= '0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_data  <= '0;
      end else begin
         case (r_state)
            LOAD: begin
               r_in_ready <= !w_last_in;
               if (w_accept) begin
                  if (r_ld_cnt == '0) r_p <= p;
                  for (int k = 0; k < c_a_len; k++) begin
                     if (r_ld_cnt == c_cnt_w'(k)) r_a[k*N +: N] <= in_data;
                  end
                  for (int k = 0; k < COLS; k++) begin
                     if (r_ld_cnt == c_cnt_w'(c_a_len + k)) r_b[k*N +: N] <= in_data;
                  end
                  if (w_last_in) begin
                     r_ld_cnt <= '0;
                     r_state  <= COMPUTE;
                  end else begin
                     r_ld_cnt <= r_ld_cnt + c_cnt_w'(1);
                  end
               end
            end
            COMPUTE: begin
               r_res   <= w_res;
               r_state <= SEND;
            end
            SEND: begin
               if (!r_out_valid) begin
                  r_out_valid <= 1'b1;
                  r_out_data  <= w_sel_data;
                  r_out_last  <= (r_out_idx == c_idx_last);
               end else if (out_ready) begin
                  if (r_out_idx == c_idx_last) begin
                     r_out_idx   <= '0;
                     r_out_valid <= 1'b0;
                     r_out_last  <= 1'b0;
                     r_out_data  <= '0;
                     r_in_ready  <= 1'b1;
                     r_state     <= LOAD;
                  end else begin
                     r_out_idx  <= w_sel_idx;
                     r_out_data <= w_sel_data;
                     r_out_last <= (w_sel_idx == c_idx_last);
                  end
               end
            end
            default: r_state <= LOAD;
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_gf_matrix_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_gf_matrix_stream
// Description : Randomised and directed bench for gf_matrix_stream (8-bit, 4x4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gf_matrix_stream;

   localparam int N    = 8;
   localparam int ROWS = 4;
   localparam int COLS = 4;
   localparam int JL   = ROWS * COLS + COLS;

   typedef logic [7:0] job_t [JL];
   typedef logic [7:0] res_t [ROWS];
   typedef bit         lst_t [ROWS];

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [8:0] p = '0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = '0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_data;
   logic       out_last;

   int cyc = 0;
   int n_checks = 0;
   int n_pass = 0;

   job_t job_mix;
   job_t job_id;

   gf_matrix_stream #(.N(N), .ROWS(ROWS), .COLS(COLS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .p         (p),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: full carry-less product, then polynomial long division.
   function automatic logic [7:0] gf_mul_ref(input logic [7:0] a, input logic [7:0] b,
                                             input logic [8:0] pp);
      logic [15:0] prod;
      prod = '0;
      for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (16'(a) << i);
      for (int d = 15; d >= 8; d--) if (prod[d]) prod = prod ^ (16'(pp) << (d - 8));
      return prod[7:0];
   endfunction

   task automatic model(input job_t j, input logic [8:0] pp, output res_t s);
      for (int i = 0; i < ROWS; i++) begin
         s[i] = '0;
         for (int c = 0; c < COLS; c++)
            s[i] = s[i] ^ gf_mul_ref(j[i*COLS+c], j[ROWS*COLS+c], pp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_job(output job_t j);
      for (int e = 0; e < JL; e++) j[e] = 8'($urandom);
   endtask

   task automatic load_job(input job_t j, input logic [8:0] pp, input int count,
                           input bit gaps, output int last_edge, output bit tmo);
      tmo = 1'b0;
      last_edge = -1;
      for (int e = 0; e < count && !tmo; e++) begin
         bit done;
         int guard;
         done  = 1'b0;
         guard = 0;
         while (!done && !tmo) begin
            in_data  = j[e];
            p        = (e == 0) ? pp : 9'($urandom);
            in_valid = !(gaps && ($urandom_range(0, 2) == 0));
            done     = in_valid && in_ready;
            tick();
            if (done) last_edge = cyc;
            guard++;
            if (guard > 40) tmo = 1'b1;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic collect(output res_t got, output lst_t lst, output int first_valid,
                          output bit tmo);
      out_ready   = 1'b1;
      tmo         = 1'b0;
      first_valid = -1;
      for (int i = 0; i < ROWS && !tmo; i++) begin
         int guard;
         guard = 0;
         while (!out_valid && !tmo) begin
            tick();
            guard++;
            if (guard > 20) tmo = 1'b1;
         end
         if (!tmo) begin
            if (first_valid < 0) first_valid = cyc;
            got[i] = out_data;
            lst[i] = out_last;
            tick();
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b exp=0", in_ready); else n_pass++;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else n_pass++;
      n_checks++; if (out_last !== 1'b0) $display("FAIL reset_out_last got=%b exp=0", out_last); else n_pass++;
      n_checks++; if (out_data !== 8'h00) $display("FAIL reset_out_data got=%h exp=00", out_data); else n_pass++;
      rst_n = 1'b1;
      tick();
      n_checks++; if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); else n_pass++;
   endtask

   task automatic test_mixcolumns();
      logic [7:0] exp [ROWS] = '{8'h8e, 8'h4d, 8'ha1, 8'hbc};
      res_t got; lst_t lst; int k, fv; bit t1, t2;
      load_job(job_mix, 9'h11B, JL, 1'b0, k, t1);
      collect(got, lst, fv, t2);
      n_checks++; if (t1 || t2) $display("FAIL mix_timeout load=%b collect=%b exp=0", t1, t2); else n_pass++;
      n_checks++; if (fv !== k + 2) $display("FAIL mix_latency got_edge=%0d exp_edge=%0d", fv, k + 2); else n_pass++;
      for (int i = 0; i < ROWS; i++) begin
         n_checks++; if (got[i] !== exp[i]) $display("FAIL mix_data[%0d] got=%h exp=%h", i, got[i], exp[i]); else n_pass++;
         n_checks++; if (lst[i] !== (i == ROWS - 1)) $display("FAIL mix_last[%0d] got=%b exp=%b", i, lst[i], i == ROWS - 1); else n_pass++;
      end
   endtask

   task automatic test_identity_gaps();
      logic [7:0] exp [ROWS] = '{8'h01, 8'h02, 8'h04, 8'h80};
      res_t got; lst_t lst; int k, fv; bit t1, t2;
      load_job(job_id, 9'h11B, JL, 1'b1, k, t1);
      collect(got, lst, fv, t2);
      n_checks++; if (t1 || t2) $display("FAIL id_timeout load=%b collect=%b exp=0", t1, t2); else n_pass++;
      for (int i = 0; i < ROWS; i++) begin
         n_checks++; if (got[i] !== exp[i]) $display("FAIL id_data[%0d] got=%h exp=%h", i, got[i], exp[i]); else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] exp [ROWS] = '{8'h8e, 8'h4d, 8'ha1, 8'hbc};
      res_t got; int k, idx, hold, guard; bit t1;
      load_job(job_mix, 9'h11B, JL, 1'b0, k, t1);
      idx = 0; hold = 0; guard = 0;
      while (idx < ROWS && guard < 60) begin
         if (idx == 1 && hold < 5) begin
            n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_valid_hold[%0d] got=%b exp=1", hold, out_valid); else n_pass++;
            n_checks++; if (out_data !== 8'h4d) $display("FAIL bp_data_hold[%0d] got=%h exp=4d", hold, out_data); else n_pass++;
            out_ready = 1'b0;
            hold++;
         end else begin
            out_ready = 1'b1;
            if (out_valid) begin
               got[idx] = out_data;
               idx++;
            end
         end
         tick();
         guard++;
      end
      n_checks++; if (t1 || idx != ROWS) $display("FAIL bp_timeout got_count=%0d exp=%0d", idx, ROWS); else n_pass++;
      for (int i = 0; i < idx; i++) begin
         n_checks++; if (got[i] !== exp[i]) $display("FAIL bp_data[%0d] got=%h exp=%h", i, got[i], exp[i]); else n_pass++;
      end
      n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_no_duplicate got_valid=%b exp=0", out_valid); else n_pass++;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_ready_return got=%b exp=1", in_ready); else n_pass++;
   endtask

   task automatic test_reset_mid_load();
      logic [7:0] exp [ROWS] = '{8'h01, 8'h02, 8'h04, 8'h80};
      res_t got; lst_t lst; int k, fv; bit t1, t2, seen;
      load_job(job_mix, 9'h11B, 10, 1'b0, k, t1);
      rst_n = 1'b0;
      tick();
      n_checks++; if ({in_ready, out_valid, out_last} !== 3'b000 || out_data !== 8'h00)
         $display("FAIL midrst_outputs got=%b%b%b/%h exp=000/00", in_ready, out_valid, out_last, out_data);
      else n_pass++;
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (8) begin
         tick();
         if (out_valid) seen = 1'b1;
      end
      n_checks++; if (seen) $display("FAIL midrst_no_output got_valid=1 exp=0"); else n_pass++;
      load_job(job_id, 9'h11B, JL, 1'b0, k, t1);
      collect(got, lst, fv, t2);
      n_checks++; if (t1 || t2) $display("FAIL midrst_timeout load=%b collect=%b exp=0", t1, t2); else n_pass++;
      for (int i = 0; i < ROWS; i++) begin
         n_checks++; if (got[i] !== exp[i]) $display("FAIL midrst_data[%0d] got=%h exp=%h", i, got[i], exp[i]); else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      job_t jobs [2];
      logic [8:0] pj [2] = '{9'h11D, 9'h11B};
      res_t s0, s1;
      logic [7:0] got [2*ROWS];
      bit lst [2*ROWS];
      int in_cnt, out_cnt, guard;
      bit busy, freed, acc, hs;
      rand_job(jobs[0]);
      rand_job(jobs[1]);
      model(jobs[0], pj[0], s0);
      model(jobs[1], pj[1], s1);
      in_cnt = 0; out_cnt = 0; guard = 0; busy = 0; freed = 0;
      out_ready = 1'b1;
      forever begin
         if (busy) begin
            n_checks++; if (in_ready !== 1'b0) $display("FAIL b2b_ready_low cyc=%0d got=%b exp=0", cyc, in_ready); else n_pass++;
         end
         if (freed) begin
            n_checks++; if (in_ready !== 1'b1) $display("FAIL b2b_ready_rise cyc=%0d got=%b exp=1", cyc, in_ready); else n_pass++;
            freed = 1'b0;
         end
         if (out_cnt >= 2 * ROWS || guard > 400) break;
         if (in_cnt < 2 * JL) begin
            in_valid = 1'b1;
            in_data  = jobs[in_cnt / JL][in_cnt % JL];
            p        = (in_cnt % JL == 0) ? pj[in_cnt / JL] : 9'($urandom);
         end else begin
            in_valid = 1'b0;
         end
         acc = in_valid && in_ready;
         hs  = out_valid;
         if (hs) begin
            got[out_cnt] = out_data;
            lst[out_cnt] = out_last;
         end
         tick();
         guard++;
         if (acc) begin
            in_cnt++;
            if (in_cnt % JL == 0) busy = 1'b1;
         end
         if (hs) begin
            out_cnt++;
            if (out_cnt % ROWS == 0) begin
               busy  = 1'b0;
               freed = 1'b1;
            end
         end
      end
      in_valid = 1'b0;
      n_checks++; if (out_cnt != 2 * ROWS) $display("FAIL b2b_timeout got_count=%0d exp=%0d", out_cnt, 2 * ROWS); else n_pass++;
      for (int i = 0; i < out_cnt; i++) begin
         logic [7:0] e;
         e = (i < ROWS) ? s0[i] : s1[i-ROWS];
         n_checks++; if (got[i] !== e) $display("FAIL b2b_data[%0d] got=%h exp=%h", i, got[i], e); else n_pass++;
         n_checks++; if (lst[i] !== (i % ROWS == ROWS - 1)) $display("FAIL b2b_last[%0d] got=%b exp=%b", i, lst[i], i % ROWS == ROWS - 1); else n_pass++;
      end
   endtask

   task automatic test_random();
      job_t j; res_t exp, got; lst_t lst; int k, fv; bit t1, t2; logic [8:0] pp;
      for (int t = 0; t < 8; t++) begin
         rand_job(j);
         pp = {1'b1, 8'($urandom)};
         if (t == 0) for (int e = 0; e < ROWS * COLS; e++) j[e] = '0;
         if (t == 1) for (int e = ROWS * COLS; e < JL; e++) j[e] = '0;
         model(j, pp, exp);
         load_job(j, pp, JL, t[0], k, t1);
         collect(got, lst, fv, t2);
         n_checks++; if (t1 || t2) $display("FAIL rnd%0d_timeout load=%b collect=%b exp=0", t, t1, t2); else n_pass++;
         for (int i = 0; i < ROWS; i++) begin
            n_checks++; if (got[i] !== exp[i]) $display("FAIL rnd%0d_data[%0d] p=%h got=%h exp=%h", t, i, pp, got[i], exp[i]); else n_pass++;
         end
      end
   endtask

   initial begin
      job_mix = '{8'h02, 8'h03, 8'h01, 8'h01,
                  8'h01, 8'h02, 8'h03, 8'h01,
                  8'h01, 8'h01, 8'h02, 8'h03,
                  8'h03, 8'h01, 8'h01, 8'h02,
                  8'hdb, 8'h13, 8'h53, 8'h45};
      job_id  = '{8'h01, 8'h00, 8'h00, 8'h00,
                  8'h00, 8'h01, 8'h00, 8'h00,
                  8'h00, 8'h00, 8'h01, 8'h00,
                  8'h00, 8'h00, 8'h00, 8'h01,
                  8'h01, 8'h02, 8'h04, 8'h80};
      test_reset();
      test_mixcolumns();
      test_identity_gaps();
      test_backpressure();
      test_reset_mid_load();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
